// File: rtl/train_seq.sv
// Iteration sequencer: issues start pulses to the phase FSM and tracks
// FP/BP/WG progress across a programmed number of iterations.
module train_seq #(
    parameter int ITER_W  = 8,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              seq_rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iter,
    input  logic              stride_cfg,
    input  logic              abort,
    input  logic              in_en,
    output logic              in,
    output logic              stride,
    output logic              busy,
    output logic [1:0]        phase,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              done,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [TO_W-1:0]   WD_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]   WD_ONE   = TO_W'(1);
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

    state_t              state, state_nxt;
    logic [ITER_W-1:0]   num_lat, num_nxt;
    logic [ITER_W-1:0]   iter_nxt, iter_inc;
    logic [TO_W-1:0]     wd, wd_nxt;
    logic [1:0]          phase_nxt;
    logic                in_nxt, stride_nxt, busy_nxt, done_nxt, to_nxt;
    logic                in_en_d, seen_low, seen_nxt, quiet, quiet_nxt;
    logic                wd_err;

    always_ff @(posedge clk or negedge seq_rst_n) begin
        if (!seq_rst_n) begin
            state       <= S_IDLE;
            num_lat     <= '0;
            wd          <= '0;
            in          <= 1'b0;
            stride      <= 1'b0;
            busy        <= 1'b0;
            phase       <= 2'd0;
            iter_cnt    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            in_en_d     <= 1'b0;
            seen_low    <= 1'b0;
            quiet       <= 1'b0;
        end else begin
            state       <= state_nxt;
            num_lat     <= num_nxt;
            wd          <= wd_nxt;
            in          <= in_nxt;
            stride      <= stride_nxt;
            busy        <= busy_nxt;
            phase       <= phase_nxt;
            iter_cnt    <= iter_nxt;
            done        <= done_nxt;
            timeout_err <= to_nxt;
            in_en_d     <= in_en;
            seen_low    <= seen_nxt;
            quiet       <= quiet_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        num_nxt    = num_lat;
        wd_nxt     = wd;
        in_nxt     = 1'b0;
        done_nxt   = 1'b0;
        stride_nxt = stride;
        busy_nxt   = busy;
        phase_nxt  = phase;
        iter_nxt   = iter_cnt;
        to_nxt     = timeout_err;
        iter_inc   = iter_cnt + ITER_ONE;
        // Two consecutive low samples mean the phase FSM has gone idle.
        seen_nxt   = !in_en;
        quiet_nxt  = !in_en && (quiet || seen_low);
        wd_err     = (state == S_WAIT || state == S_RUN)
                     && !in_en && (wd == WD_LAST);

        unique case (state)
            S_IDLE: begin
                if (start && quiet) begin
                    stride_nxt = stride_cfg;
                    iter_nxt   = '0;
                    to_nxt     = 1'b0;
                    busy_nxt   = 1'b1;
                    if (num_iter != '0) begin
                        num_nxt   = num_iter;
                        in_nxt    = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                wd_nxt    = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (in_en) begin
                    wd_nxt    = '0;
                    phase_nxt = 2'd1;
                    state_nxt = S_RUN;
                end else begin
                    wd_nxt = wd + WD_ONE;
                end
            end
            S_RUN: begin
                wd_nxt = in_en ? '0 : wd + WD_ONE;
                if (in_en_d && !in_en) begin
                    if (phase != 2'd3) begin
                        phase_nxt = phase + 2'd1;
                    end else begin
                        iter_nxt  = iter_inc;
                        phase_nxt = 2'd0;
                        if (iter_inc == num_lat) begin
                            done_nxt  = 1'b1;
                            state_nxt = S_DONE;
                        end else begin
                            in_nxt    = 1'b1;
                            state_nxt = S_ISSUE;
                        end
                    end
                end
            end
            S_DONE: begin
                busy_nxt  = 1'b0;
                phase_nxt = 2'd0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (wd_err) begin
            to_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            phase_nxt = 2'd0;
            in_nxt    = 1'b0;
            done_nxt  = 1'b0;
            iter_nxt  = iter_cnt;
            wd_nxt    = '0;
            state_nxt = S_IDLE;
        end

        // Abort outranks both timeout and a coincident final phase end.
        if (abort && state != S_IDLE) begin
            to_nxt    = timeout_err;
            busy_nxt  = 1'b0;
            phase_nxt = 2'd0;
            in_nxt    = 1'b0;
            done_nxt  = 1'b0;
            iter_nxt  = iter_cnt;
            wd_nxt    = '0;
            state_nxt = S_IDLE;
        end
    end

endmodule

// File: tb/tb_train_seq.sv
// Directed bench for train_seq with a behavioural phase FSM that answers
// each start pulse with the 12-cycle FP/BP/WG in_en pattern.
module tb_train_seq;

    logic       clk = 1'b0;
    logic       seq_rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_iter = 8'd0;
    logic       stride_cfg = 1'b0;
    logic       abort = 1'b0;
    logic       in_en = 1'b0;
    logic       in, stride, busy, done, timeout_err;
    logic [1:0] phase;
    logic [7:0] iter_cnt;

    train_seq #(.ITER_W(8), .TO_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .seq_rst_n(seq_rst_n), .start(start),
        .num_iter(num_iter), .stride_cfg(stride_cfg), .abort(abort),
        .in_en(in_en), .in(in), .stride(stride), .busy(busy),
        .phase(phase), .iter_cnt(iter_cnt), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [7:0] num;
        logic       scfg;
        logic       e_in;
        logic       e_busy;
        logic [1:0] e_ph;
        logic [7:0] e_it;
        logic       e_done;
        logic       e_to;
        logic       e_str;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int fcnt = 0;
    bit tie0 = 1'b0;
    logic s_in, s_busy, s_done, s_to, s_str;
    logic [1:0] s_ph;
    logic [7:0] s_it;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, then advance the FSM model.
    task automatic cyc();
        @(negedge clk);
        s_in = in; s_busy = busy; s_ph = phase; s_it = iter_cnt;
        s_done = done; s_to = timeout_err; s_str = stride;
        @(posedge clk);
        #1;
        if (fcnt != 0) fcnt = (fcnt == 12) ? 0 : fcnt + 1;
        if (s_in) fcnt = 1;
        in_en = !tie0 && (fcnt inside {1, 2, 3, 5, 6, 7, 9, 10, 11});
    endtask

    function automatic vec_t v(logic st, logic ei, logic eb, logic [1:0] ep,
                               logic [7:0] eit, logic ed, logic es);
        vec_t r;
        r.st = st; r.num = 8'd1; r.scfg = 1'b1;
        r.e_in = ei; r.e_busy = eb; r.e_ph = ep; r.e_it = eit;
        r.e_done = ed; r.e_to = 1'b0; r.e_str = es;
        return r;
    endfunction

    vec_t tbl[18];
    int ipos[$];
    int dpos[$];
    int acc;
    int c0;
    int dcnt;

    initial begin
        // rows: r0, r1 (start ignored, not quiet), c0 .. c15
        tbl[0]  = v(1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = v(1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = v(0, 1, 1, 0, 0, 0, 1);
        tbl[4]  = v(0, 0, 1, 0, 0, 0, 1);
        tbl[5]  = v(0, 0, 1, 1, 0, 0, 1);
        tbl[6]  = v(0, 0, 1, 1, 0, 0, 1);
        tbl[7]  = v(0, 0, 1, 1, 0, 0, 1);
        tbl[8]  = v(0, 0, 1, 2, 0, 0, 1);
        tbl[9]  = v(0, 0, 1, 2, 0, 0, 1);
        tbl[10] = v(0, 0, 1, 2, 0, 0, 1);
        tbl[11] = v(0, 0, 1, 2, 0, 0, 1);
        tbl[12] = v(0, 0, 1, 3, 0, 0, 1);
        tbl[13] = v(0, 0, 1, 3, 0, 0, 1);
        tbl[14] = v(0, 0, 1, 3, 0, 0, 1);
        tbl[15] = v(0, 0, 1, 3, 0, 0, 1);
        tbl[16] = v(0, 0, 1, 0, 1, 1, 1);
        tbl[17] = v(0, 0, 0, 0, 1, 0, 1);

        repeat (2) @(posedge clk);
        #1 seq_rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            start = tbl[i].st;
            num_iter = tbl[i].num;
            stride_cfg = tbl[i].scfg;
            cyc();
            chk($sformatf("t1[%0d].in", i), s_in, tbl[i].e_in);
            chk($sformatf("t1[%0d].busy", i), s_busy, tbl[i].e_busy);
            chk($sformatf("t1[%0d].phase", i), s_ph, tbl[i].e_ph);
            chk($sformatf("t1[%0d].iter", i), s_it, tbl[i].e_it);
            chk($sformatf("t1[%0d].done", i), s_done, tbl[i].e_done);
            chk($sformatf("t1[%0d].to", i), s_to, tbl[i].e_to);
            chk($sformatf("t1[%0d].stride", i), s_str, tbl[i].e_str);
        end
        start = 1'b0;
        repeat (3) cyc();

        // three back-to-back iterations
        start = 1'b1; num_iter = 8'd3; stride_cfg = 1'b0;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            cyc();
            if (s_in) ipos.push_back(k);
            if (s_done) dpos.push_back(k);
            if (k == 1) chk("t2.stride", s_str, 0);
            if (k == 14) chk("t2.iter14", s_it, 1);
            if (k == 40) chk("t2.iter40", s_it, 3);
            if (k == 41) chk("t2.busy41", s_busy, 0);
        end
        chk("t2.in_count", ipos.size(), 3);
        if (ipos.size() == 3) begin
            chk("t2.in0", ipos[0], 1);
            chk("t2.in1", ipos[1], 14);
            chk("t2.in2", ipos[2], 27);
        end
        chk("t2.done_count", dpos.size(), 1);
        if (dpos.size() == 1) chk("t2.done_at", dpos[0], 40);

        // zero iterations
        start = 1'b1; num_iter = 8'd0;
        cyc();
        start = 1'b0;
        cyc();
        chk("t3.done", s_done, 1);
        chk("t3.iter", s_it, 0);
        chk("t3.in", s_in, 0);
        chk("t3.busy1", s_busy, 1);
        cyc();
        chk("t3.busy2", s_busy, 0);
        chk("t3.done2", s_done, 0);

        // watchdog with in_en stuck low
        tie0 = 1'b1; in_en = 1'b0;
        start = 1'b1; num_iter = 8'd2;
        cyc();
        start = 1'b0;
        dcnt = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (s_done) dcnt++;
            if (k == 9) begin
                chk("t4.busy9", s_busy, 1);
                chk("t4.to9", s_to, 0);
            end
            if (k == 10) begin
                chk("t4.to10", s_to, 1);
                chk("t4.busy10", s_busy, 0);
            end
        end
        chk("t4.no_done", dcnt, 0);
        start = 1'b1; num_iter = 8'd0;
        cyc();
        start = 1'b0;
        cyc();
        chk("t4.to_clear", s_to, 0);
        chk("t4.done", s_done, 1);
        cyc();
        tie0 = 1'b0;
        repeat (3) cyc();

        // abort during BP, then restart once the phase FSM is quiet
        start = 1'b1; num_iter = 8'd2; stride_cfg = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) cyc();
        chk("t5.phase6", s_ph, 2);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
        chk("t5.busy8", s_busy, 0);
        chk("t5.phase8", s_ph, 0);
        chk("t5.iter8", s_it, 0);
        chk("t5.stride8", s_str, 1);
        chk("t5.done8", s_done, 0);
        acc = -1;
        num_iter = 8'd1; stride_cfg = 1'b0;
        for (int k = 9; k <= 30; k++) begin
            start = 1'b1;
            cyc();
            if (s_busy) begin
                acc = k - 1;
                break;
            end
        end
        start = 1'b0;
        chk("t5.accept_at", acc, 15);

        // start while busy is ignored (now in c1 of the restarted run)
        for (int k = 2; k <= 15; k++) begin
            start = (k <= 12);
            num_iter = 8'd9;
            cyc();
            if (k == 5) chk("t6.stride", s_str, 0);
            if (k == 14) begin
                chk("t6.done", s_done, 1);
                chk("t6.iter", s_it, 1);
            end
            if (k == 15) chk("t6.busy", s_busy, 0);
        end
        start = 1'b0;
        repeat (3) cyc();

        // asynchronous reset mid-run
        start = 1'b1; num_iter = 8'd4; stride_cfg = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) cyc();
        #1;
        chk("t7.busy_pre", busy, 1);
        chk("t7.phase_pre", phase, 2);
        seq_rst_n = 1'b0;
        #1;
        chk("t7.busy", busy, 0);
        chk("t7.phase", phase, 0);
        chk("t7.stride", stride, 0);
        chk("t7.in", in, 0);
        chk("t7.done", done, 0);
        chk("t7.iter", iter_cnt, 0);
        fcnt = 0; in_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 seq_rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (s_done) dcnt++;
        end
        chk("t7.no_done", dcnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/train_seq.md
# train_seq

Iteration sequencer for the training-phase controller. It issues the one-cycle `in` start pulse and the held `stride` level to that controller. It then follows the controller's `in_en` strobe through the forward (FP), backward (BP) and weight (WG) phases, and repeats for a programmed number of iterations. It sits between the host register interface and the phase FSM, and reports progress, completion and watchdog timeouts back to the host.

## Interface
- `ITER_W`, 8: width of the iteration count.
- `TO_W`, 4: width of the watchdog counter.
- `TIMEOUT`, 8: consecutive `in_en`-low cycles (in WAIT or RUN) that trigger a timeout; must be ≥2 and <2^TO_W.
- `clk` input 1: clock, rising edge.
- `seq_rst_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` input 1: request a run; sampled only in IDLE.
- `num_iter` input ITER_W: iterations to run; sampled with `start`.
- `stride_cfg` input 1: stride mode; sampled with `start`.
- `abort` input 1: synchronous run cancel.
- `in_en` input 1: phase-active strobe from the phase FSM.
- `in` output 1: start pulse to the phase FSM.
- `stride` output 1: latched stride, held for the whole run.
- `busy` output 1: run in progress.
- `phase` output 2: 0 none, 1 FP, 2 BP, 3 WG.
- `iter_cnt` output ITER_W: completed iterations of the current or last run.
- `done` output 1: one-cycle run-complete pulse.
- `timeout_err` output 1: sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT, RUN, DONE. All outputs are registered.
- **Quiet detector:** `quiet` is set after `in_en` has been low for 2 consecutive cycles, and is cleared by any `in_en` high. This means the phase FSM is in its idle state.
- **IDLE:** `start`=1 is accepted only if `quiet`=1; otherwise it is ignored and not remembered.
  - Accept with `num_iter`≠0:
    - latch `num_iter`;
    - set `stride`←`stride_cfg`;
    - clear `iter_cnt` and `timeout_err`;
    - set `busy`=1;
    - go to ISSUE.
  - Accept with `num_iter`=0: go to DONE directly, `iter_cnt`=0, no `in` pulse.
- **ISSUE:** drive `in`=1 for exactly this cycle, then go to WAIT with the watchdog cleared.
- **WAIT:**
  - `in_en`=1 → RUN, `phase`←1.
  - Otherwise the watchdog increments. On reaching TIMEOUT: set `timeout_err`=1, `busy`=0, `phase`=0, go to IDLE. No `done` is issued.
- **RUN:** a phase end is `in_en_d`=1 and `in_en`=0, where `in_en_d` is `in_en` registered.
  - Phase end with `phase`<3: `phase` increments.
  - Phase end with `phase`=3: `iter_cnt`++. If the new count equals the latched `num_iter` → DONE; otherwise → ISSUE (back-to-back, no gap).
  - Watchdog: counts consecutive `in_en`-low cycles and clears on `in_en`=1. Reaching TIMEOUT gives the same error exit as in WAIT.
- **DONE:** `done`=1 for one cycle, `busy`=1 in this cycle, `phase`=0, then go to IDLE.
- **`abort`=1 in any non-IDLE state:** next cycle IDLE, `busy`=0, `in`=0, `phase`=0, no `done`, `iter_cnt` holds, `stride` holds. `abort` in IDLE has no effect.
- **Priority:** reset > `abort` > timeout > normal transitions. An `abort` in the same cycle as a final phase end wins: no `done`, and `iter_cnt` is not incremented.
- **Width rules:** `iter_cnt` never wraps because a run stops at `num_iter` ≤ 2^ITER_W−1. The watchdog saturates at TIMEOUT.
- **`stride`:** changes only on an accepted `start`.

## Timing
- **Reset values:** state IDLE, and `in`, `stride`, `busy`, `phase`, `iter_cnt`, `done`, `timeout_err`, `quiet`, `in_en_d`, watchdog all 0.
- Reset mid-run aborts immediately and asynchronously with no `done`.
- `quiet` becomes 1 at the second cycle after reset release, so `start` in the first 2 cycles is ignored.
- **Cycle numbering:** `start` sampled in cycle c0.
  - c1: `in`=1.
  - FSM `in_en` pattern: high c2–c4, low c5, high c6–c8, low c9, high c10–c12, low c13.
  - `phase`: =1 from c3, =2 from c6, =3 from c10.
  - c14: `iter_cnt` increments, and either `done`=1 or the next `in`=1.
- Iteration period is 13 cycles.
- `done` of an N-iteration run falls at c0+1+13N.

## Test plan
- Reset, wait 2 cycles, `start` with `num_iter`=1, `stride_cfg`=1, driven by the real phase FSM → `in` high only in c1; `phase` 1/2/3 at c3/c6/c10; `done` and `iter_cnt`=1 at c14; `stride`=1 throughout; `busy` low at c15.
- `num_iter`=3 → `in` pulses at c1, c14, c27; single `done` at c40; `iter_cnt`=3.
- `in_en` tied 0, TIMEOUT=8 → `timeout_err`=1 and `busy`=0 at c10; no `done`; `timeout_err` clears on the next accepted `start`.
- `num_iter`=0 → no `in` pulse; `done` at c1; `iter_cnt`=0.
- `abort` during BP (c7) → `busy`=0 at c8, `iter_cnt`=0; `start` at c9 ignored (FSM still running, `quiet`=0); `start` accepted 2 cycles after FSM `in_en` stays low.
- `start` while `busy` → ignored. Assert `seq_rst_n` low at c8 → all outputs 0 immediately, no `done`.
